// File: rtl/mdu_ctrl_pkg.sv
// Shared CPU constants for the multiply/divide unit: op codes, sequencer states and a helper.
`default_nettype none

package mdu_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_e;

    localparam int unsigned MDU_W     = 32;
    localparam logic [4:0]  LAST_STEP = 5'd31;

    function automatic logic [MDU_W-1:0] neg32(input logic [MDU_W-1:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply or restoring-subtract divide on a 64-bit accumulator.
`default_nettype none

module mdu_step (
    input  logic        div_i,
    input  logic [63:0] acc_i,
    input  logic [31:0] opnd_i,
    output logic [63:0] acc_o
);

    logic [32:0] w_add;
    logic [32:0] w_rem_sh;
    logic [32:0] w_sub;
    logic        w_ge;

    // Multiply: acc = {partial product, remaining multiplier bits}; carry lands in bit 63 after the shift.
    assign w_add    = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);

    // Divide: acc = {remainder, dividend/quotient}; shifting brings the next dividend bit into the remainder.
    assign w_rem_sh = acc_i[63:31];
    assign w_ge     = (w_rem_sh >= {1'b0, opnd_i});
    assign w_sub    = w_rem_sh - {1'b0, opnd_i};

    always_comb begin
        acc_o = {w_add, acc_i[31:1]};
        if (div_i) begin
            if (w_ge) begin
                acc_o = {w_sub[31:0], acc_i[30:0], 1'b1};
            end else begin
                acc_o = {acc_i[62:0], 1'b0};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: sequences 32 datapath steps, applies sign correction and owns HI/LO.
`default_nettype none

module mdu_ctrl (
    input  logic        clk,
    input  logic        clrn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wd,
    input  logic        rd_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        dz,
    output logic        stall
);

    import mdu_ctrl_pkg::*;

    mdu_state_e  state_q, state_d;
    mdu_op_e     op_q, op_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;

    logic        w_signed_in;
    logic        w_sa_in;
    logic        w_sb_in;
    logic        w_is_div;
    logic        w_div_zero;
    logic        w_neg_res;
    logic [63:0] w_step;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_signed_in = (op == OP_MULT) || (op == OP_DIV);
    assign w_sa_in     = w_signed_in & a[31];
    assign w_sb_in     = w_signed_in & b[31];

    assign w_is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign w_div_zero  = w_is_div && (opnd_q == 32'd0);
    assign w_neg_res   = sa_q ^ sb_q;

    mdu_step u_step (
        .div_i  (w_is_div),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (w_step)
    );

    assign w_prod = w_neg_res ? (~acc_q + 64'd1) : acc_q;
    // A zero divisor leaves the quotient all-ones regardless of operand signs.
    assign w_quot = w_div_zero ? 32'hFFFF_FFFF :
                    (w_neg_res ? neg32(acc_q[31:0]) : acc_q[31:0]);
    assign w_rem  = sa_q ? neg32(acc_q[63:32]) : acc_q[63:32];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = mdu_op_e'(op);
                    sa_d    = w_sa_in;
                    sb_d    = w_sb_in;
                    acc_d   = {32'd0, (w_sa_in ? neg32(a) : a)};
                    opnd_d  = w_sb_in ? neg32(b) : b;
                    cnt_d   = 5'd0;
                    state_d = ST_CALC;
                end else begin
                    if (hi_we) hi_d = wd;
                    if (lo_we) lo_d = wd;
                end
            end
            ST_CALC: begin
                acc_d = w_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (w_is_div) begin
                    hi_d = w_rem;
                    lo_d = w_quot;
                end else begin
                    hi_d = w_prod[63:32];
                    lo_d = w_prod[31:0];
                end
                done_d  = 1'b1;
                dz_d    = w_div_zero;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            opnd_q  <= 32'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;
    assign dz    = dz_q;
    assign stall = busy & (rd_req | start | hi_we | lo_we);

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with hand-computed expected results.
`default_nettype none

module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        clrn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wd;
    logic        rd_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        dz;
    logic        stall;

    int vectors = 0;
    int errors  = 0;

    mdu_ctrl dut (
        .clk    (clk),
        .clrn   (clrn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wd     (wd),
        .rd_req (rd_req),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done),
        .dz     (dz),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and waits (bounded) for done; lat counts edges from the start edge.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic [31:0] rh, output logic [31:0] rl,
                         output logic rdz);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        rh = hi; rl = lo; rdz = dz;
    endtask

    task automatic test_reset();
        vectors++;
        if ({hi, lo, busy, done, dz, stall} !== 68'd0) begin
            errors++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dz=%b stall=%b expected all zero",
                     hi, lo, busy, done, dz, stall);
        end
    endtask

    task automatic test_multu();
        int lat; logic [31:0] rh, rl; logic rdz;
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, rh, rl, rdz);
        vectors++;
        if (lat !== 34) begin errors++; $display("FAIL multu_latency: got %0d expected 34", lat); end
        vectors++;
        if ({rh, rl, rdz} !== {32'hFFFF_FFFE, 32'h0000_0001, 1'b0}) begin
            errors++; $display("FAIL multu_max: got hi=%h lo=%h dz=%b expected hi=fffffffe lo=00000001 dz=0", rh, rl, rdz);
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got done=%b expected 0", done); end
    endtask

    task automatic test_mult();
        int lat; logic [31:0] rh, rl; logic rdz;
        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat, rh, rl, rdz);
        vectors++;
        if ({rh, rl} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB}) begin
            errors++; $display("FAIL mult_neg3x7: got hi=%h lo=%h expected hi=ffffffff lo=ffffffeb", rh, rl);
        end
        do_op(2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, lat, rh, rl, rdz);
        vectors++;
        if ({rh, rl} !== {32'h0, 32'h0000_001E}) begin
            errors++; $display("FAIL mult_neg5xneg6: got hi=%h lo=%h expected hi=00000000 lo=0000001e", rh, rl);
        end
        do_op(2'b00, 32'h8000_0000, 32'd2, lat, rh, rl, rdz);
        vectors++;
        if ({rh, rl, lat} !== {32'hFFFF_FFFF, 32'h0, 34}) begin
            errors++; $display("FAIL mult_minx2: got hi=%h lo=%h lat=%0d expected hi=ffffffff lo=00000000 lat=34", rh, rl, lat);
        end
    endtask

    task automatic test_div();
        int lat; logic [31:0] rh, rl; logic rdz;
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, rh, rl, rdz);
        vectors++;
        if ({rl, rh, rdz} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0}) begin
            errors++; $display("FAIL div_neg7by2: got lo=%h hi=%h dz=%b expected lo=fffffffd hi=ffffffff dz=0", rl, rh, rdz);
        end
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE, lat, rh, rl, rdz);
        vectors++;
        if ({rl, rh} !== {32'hFFFF_FFFD, 32'h0000_0001}) begin
            errors++; $display("FAIL div_7byneg2: got lo=%h hi=%h expected lo=fffffffd hi=00000001", rl, rh);
        end
        do_op(2'b11, 32'd100, 32'd7, lat, rh, rl, rdz);
        vectors++;
        if ({rl, rh, lat} !== {32'd14, 32'd2, 34}) begin
            errors++; $display("FAIL divu_100by7: got lo=%h hi=%h lat=%0d expected lo=0000000e hi=00000002 lat=34", rl, rh, lat);
        end
        do_op(2'b11, 32'hFFFF_FFFF, 32'd2, lat, rh, rl, rdz);
        vectors++;
        if ({rl, rh} !== {32'h7FFF_FFFF, 32'h0000_0001}) begin
            errors++; $display("FAIL divu_maxby2: got lo=%h hi=%h expected lo=7fffffff hi=00000001", rl, rh);
        end
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, rh, rl, rdz);
        vectors++;
        if ({rl, rh, rdz} !== {32'h8000_0000, 32'h0, 1'b0}) begin
            errors++; $display("FAIL div_overflow: got lo=%h hi=%h dz=%b expected lo=80000000 hi=00000000 dz=0", rl, rh, rdz);
        end
    endtask

    task automatic test_div_zero();
        int lat; logic [31:0] rh, rl; logic rdz;
        do_op(2'b11, 32'd100, 32'd0, lat, rh, rl, rdz);
        vectors++;
        if ({rl, rh, rdz, lat} !== {32'hFFFF_FFFF, 32'd100, 1'b1, 34}) begin
            errors++; $display("FAIL divu_by_zero: got lo=%h hi=%h dz=%b lat=%0d expected lo=ffffffff hi=00000064 dz=1 lat=34",
                               rl, rh, rdz, lat);
        end
        tick();
        vectors++;
        if (dz !== 1'b0) begin errors++; $display("FAIL dz_clears: got dz=%b expected 0", dz); end
        do_op(2'b10, 32'hFFFF_FFFB, 32'd0, lat, rh, rl, rdz);
        vectors++;
        if ({rl, rh, rdz} !== {32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1}) begin
            errors++; $display("FAIL div_neg_by_zero: got lo=%h hi=%h dz=%b expected lo=ffffffff hi=fffffffb dz=1", rl, rh, rdz);
        end
    endtask

    task automatic test_stall_write();
        int lat;
        hi_we = 1'b1; wd = 32'h0000_1234;
        tick();
        hi_we = 1'b0;
        vectors++;
        if (hi !== 32'h0000_1234) begin errors++; $display("FAIL idle_hi_write: got %h expected 00001234", hi); end
        lo_we = 1'b1; wd = 32'h0000_5678;
        tick();
        lo_we = 1'b0;
        vectors++;
        if ({hi, lo} !== {32'h0000_1234, 32'h0000_5678}) begin
            errors++; $display("FAIL idle_lo_write: got hi=%h lo=%h expected hi=00001234 lo=00005678", hi, lo);
        end
        // start and a write together: start wins
        start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3; hi_we = 1'b1; wd = 32'h0000_DEAD;
        tick();
        start = 1'b0; hi_we = 1'b0;
        vectors++;
        if ({busy, hi} !== {1'b1, 32'h0000_1234}) begin
            errors++; $display("FAIL start_beats_write: got busy=%b hi=%h expected busy=1 hi=00001234", busy, hi);
        end
        rd_req = 1'b1; hi_we = 1'b1; wd = 32'h0000_ABCD;
        #1;
        vectors++;
        if (stall !== 1'b1) begin errors++; $display("FAIL stall_busy_write: got %b expected 1", stall); end
        tick();
        vectors++;
        if (hi !== 32'h0000_1234) begin errors++; $display("FAIL busy_write_ignored: got %h expected 00001234", hi); end
        hi_we = 1'b0;
        #1;
        vectors++;
        if (stall !== 1'b1) begin errors++; $display("FAIL stall_rd_only: got %b expected 1", stall); end
        rd_req = 1'b0;
        #1;
        vectors++;
        if (stall !== 1'b0) begin errors++; $display("FAIL stall_idle_inputs: got %b expected 0", stall); end
        lat = 2;
        while (done !== 1'b1 && lat < 60) begin tick(); lat++; end
        vectors++;
        if ({hi, lo, lat} !== {32'd0, 32'd6, 34}) begin
            errors++; $display("FAIL multu_2x3_after_stall: got hi=%h lo=%h lat=%0d expected hi=0 lo=6 lat=34", hi, lo, lat);
        end
        rd_req = 1'b1; hi_we = 1'b1; wd = 32'h0000_1234;
        #1;
        vectors++;
        if (stall !== 1'b0) begin errors++; $display("FAIL no_stall_idle: got %b expected 0", stall); end
        tick();
        rd_req = 1'b0; hi_we = 1'b0;
        vectors++;
        if (hi !== 32'h0000_1234) begin errors++; $display("FAIL idle_write_after_op: got %h expected 00001234", hi); end
    endtask

    task automatic test_abort();
        int lat; logic [31:0] rh, rl; logic rdz;
        bit seen_done;
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
        tick();
        start = 1'b0;
        repeat (9) tick();
        vectors++;
        if ({busy, hi, lo} !== {1'b1, 32'h0000_1234, 32'd6}) begin
            errors++; $display("FAIL hold_during_calc: got busy=%b hi=%h lo=%h expected busy=1 hi=00001234 lo=00000006", busy, hi, lo);
        end
        clrn = 1'b0;
        #1;
        vectors++;
        if ({busy, hi, lo, done, dz, stall} !== 68'd0) begin
            errors++; $display("FAIL async_abort: got busy=%b hi=%h lo=%h done=%b dz=%b stall=%b expected all zero",
                               busy, hi, lo, done, dz, stall);
        end
        tick();
        clrn = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            tick();
            if (done === 1'b1) seen_done = 1'b1;
        end
        vectors++;
        if (seen_done !== 1'b0) begin errors++; $display("FAIL no_done_after_abort: got done pulse expected none"); end
        do_op(2'b00, 32'd5, 32'd6, lat, rh, rl, rdz);
        vectors++;
        if ({rh, rl, lat} !== {32'd0, 32'd30, 34}) begin
            errors++; $display("FAIL mult_after_abort: got hi=%h lo=%h lat=%0d expected hi=0 lo=0000001e lat=34", rh, rl, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rh, rl; logic rdz;
        do_op(2'b01, 32'd3, 32'd4, lat, rh, rl, rdz);
        vectors++;
        if ({done, busy, rl} !== {1'b1, 1'b0, 32'd12}) begin
            errors++; $display("FAIL b2b_first: got done=%b busy=%b lo=%h expected done=1 busy=0 lo=0000000c", done, busy, rl);
        end
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd9;
        tick();
        start = 1'b0;
        vectors++;
        if ({busy, done} !== {1'b1, 1'b0}) begin
            errors++; $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        lat = 1;
        while (done !== 1'b1 && lat < 60) begin tick(); lat++; end
        vectors++;
        if ({lo, hi, lat} !== {32'd11, 32'd1, 34}) begin
            errors++; $display("FAIL b2b_second: got lo=%h hi=%h lat=%0d expected lo=0000000b hi=00000001 lat=34", lo, hi, lat);
        end
    endtask

    initial begin
        clrn = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0; wd = 32'd0; rd_req = 1'b0;
        repeat (2) tick();
        test_reset();
        clrn = 1'b1;
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_stall_write();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port clrn, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-004 SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports a and b, input, 32 bits each: operands (dividend a, divisor b), sampled with start.
REQ-006 SHALL have ports hi_we and lo_we, input, 1 bit each, and wd, input, 32 bits: mthi/mtlo write.
REQ-007 SHALL have port rd_req, input, 1 bit: the pipeline is issuing mfhi/mflo this cycle.
REQ-008 SHALL have ports hi and lo, output, 32 bits each: architectural HI/LO registers.
REQ-009 SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO receive a result.
REQ-011 SHALL have port dz, output, 1 bit: divide-by-zero flag, valid only while done=1.
REQ-012 SHALL have port stall, output, 1 bit: freeze the pipeline; stall = busy & (rd_req | start | hi_we | lo_we).

Function
REQ-013 SHALL implement states IDLE, CALC and FIX; busy=1 in CALC and FIX.
REQ-014 IDLE with start=1 at edge E0 SHALL latch |a|, |b| (signed ops) or a, b (unsigned ops), sign flags and op, clear the 5-bit counter and enter CALC.
REQ-015 CALC SHALL perform one shift-add (multiply) or one restoring-subtract (divide) step per cycle for 32 cycles (edges E1..E32), then enter FIX.
REQ-016 FIX SHALL apply sign correction at edge E33, write HI/LO, pulse done for the following cycle and return to IDLE; latency from start to done is fixed at 34 cycles for every op and operand.
REQ-017 Multiply SHALL produce a 64-bit product: HI = upper 32 bits, LO = lower 32 bits; the product is negated when sign(a)^sign(b) for MULT.
REQ-018 Divide SHALL set LO = quotient and HI = remainder; for DIV, quotient sign = sign(a)^sign(b) and remainder sign = sign(a) (truncation toward zero).
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL wrap to LO=0x80000000, HI=0.
REQ-020 Divide with b=0 SHALL give LO=0xFFFFFFFF, HI=a unchanged and dz=1 with done, at the same 34-cycle latency.
REQ-021 In IDLE, hi_we/lo_we SHALL load wd into HI/LO at the next edge; if start=1 in the same cycle, start wins and the writes are dropped.
REQ-022 While busy, start, hi_we and lo_we SHALL be ignored, with the pipeline held via stall.
REQ-023 A new start SHALL be accepted in the cycle in which done=1 (state IDLE).
REQ-024 hi and lo SHALL hold their previous values during CALC/FIX; partial results never appear on them.

Reset
REQ-025 clrn=0 SHALL immediately force state IDLE, counter 0, hi=0, lo=0, busy=0, done=0, dz=0 and stall=0, including in mid-operation; the aborted result is discarded.
REQ-026 The first start SHALL be accepted at the first rising edge after clrn deasserts.

Structure
REQ-027 The op encodings (MULT/MULTU/DIV/DIVU) and state encodings SHALL live in the shared CPU constants package, for use by the decoder.
REQ-028 The per-cycle iteration step (shift-add / restoring subtract on the 64-bit accumulator) SHALL be one combinational sub-module, mdu_step; sequencing, sign handling and HI/LO storage SHALL remain in mdu_ctrl.

Verification
REQ-029 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done exactly 34 cycles after the start edge.
REQ-030 MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-031 DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100, dz=1 with done; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-032 rd_req=1 and hi_we=1 with wd=0x1234 driven while busy -> stall=1 and HI unchanged; the same write in IDLE -> HI=0x1234 next cycle.
REQ-033 clrn pulsed low 10 cycles into a MULT -> busy=0, hi=lo=0 at once, no done pulse; the next start completes normally.
REQ-034 Back-to-back: start asserted in the done cycle -> second op accepted, busy stays 1, second done 34 cycles later.
